// File: rtl/orb_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : orb_window_pkg
// Description : Shared constants, pixel/column types and coordinate helpers
//               for the ORB sliding patch window.
// Revision    : 1.0 - initial release
// ============================================================================
package orb_window_pkg;

    localparam int C_LUMA_BITS     = 8;
    localparam int C_WINDOW_SIZE_X = 7;
    localparam int C_WINDOW_SIZE_Y = 5;
    localparam int C_COORD_BITS    = 3;
    localparam int C_MOMENT_BITS   = 16;

    typedef logic [C_LUMA_BITS-1:0]      pixel_t;
    typedef pixel_t [C_WINDOW_SIZE_Y-1:0] column_t;

    // Centre-relative signed coordinate to zero-based array index.
    function automatic int coord_to_idx(input int coord, input int half);
        return coord + half;
    endfunction

    // True when a centre-relative coordinate lies inside [-half, +half].
    function automatic logic coord_in_range(input int coord, input int half);
        return (coord >= -half) && (coord <= half);
    endfunction

endpackage
`default_nettype wire

// File: rtl/orb_moment_calc.sv
`default_nettype none
// ============================================================================
// Module      : orb_moment_calc
// Description : Combinational intensity moments over a patch window:
//               sum(x*I) and sum(y*I) with centre-relative signed weights.
//               Results wrap at MOMENT_BITS.
// Revision    : 1.0 - initial release
// ============================================================================
module orb_moment_calc #(
    parameter int LUMA_BITS     = 8,
    parameter int WINDOW_SIZE_X = 7,
    parameter int WINDOW_SIZE_Y = 5,
    parameter int MOMENT_BITS   = 16
) (
    input  logic [WINDOW_SIZE_X-1:0][WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0] win,
    output logic signed [MOMENT_BITS-1:0]                               xmoment,
    output logic signed [MOMENT_BITS-1:0]                               ymoment
);

    localparam int C_HALF_X = (WINDOW_SIZE_X - 1) / 2;
    localparam int C_HALF_Y = (WINDOW_SIZE_Y - 1) / 2;
    localparam int C_NPIX   = WINDOW_SIZE_X * WINDOW_SIZE_Y;

    // Running partial sums; element i holds the sum of the first i terms.
    logic [C_NPIX:0][MOMENT_BITS-1:0] w_sum_x;
    logic [C_NPIX:0][MOMENT_BITS-1:0] w_sum_y;

    assign w_sum_x[0] = '0;
    assign w_sum_y[0] = '0;

    for (genvar k = 0; k < WINDOW_SIZE_X; k++) begin : g_col
        for (genvar r = 0; r < WINDOW_SIZE_Y; r++) begin : g_row
            localparam int C_IDX = k * WINDOW_SIZE_Y + r;
            localparam int C_WX  = k - C_HALF_X;
            localparam int C_WY  = r - C_HALF_Y;
            assign w_sum_x[C_IDX+1] = w_sum_x[C_IDX] + MOMENT_BITS'(C_WX * int'(win[k][r]));
            assign w_sum_y[C_IDX+1] = w_sum_y[C_IDX] + MOMENT_BITS'(C_WY * int'(win[k][r]));
        end
    end

    assign xmoment = w_sum_x[C_NPIX];
    assign ymoment = w_sum_y[C_NPIX];

endmodule
`default_nettype wire

// File: rtl/orb_window.sv
`default_nettype none
// ============================================================================
// Module      : orb_window
// Description : Sliding luma patch buffer for ORB. Write mode shifts in one
//               column per valid cycle and registers the x/y intensity
//               moments; read mode freezes the window and returns the pixels
//               at two signed sample coordinates.
//               Optional macro ORB_WINDOW_PIX_REG_EN: register out_pix1/2
//               (one cycle latency from in_coord).
// Revision    : 1.0 - initial release
// ============================================================================
module orb_window
    import orb_window_pkg::*;
#(
    parameter int LUMA_BITS     = C_LUMA_BITS,
    parameter int WINDOW_SIZE_X = C_WINDOW_SIZE_X,
    parameter int WINDOW_SIZE_Y = C_WINDOW_SIZE_Y,
    parameter int COORD_BITS    = C_COORD_BITS,
    parameter int MOMENT_BITS   = C_MOMENT_BITS
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    input  logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0]    in_col,
    input  logic signed [2*COORD_BITS-1:0]             in_coord1,
    input  logic signed [2*COORD_BITS-1:0]             in_coord2,
    input  logic                                       in_flush,
    input  logic                                       in_mode,
    output logic                                       out_patch_valid,
    output logic [LUMA_BITS-1:0]                       out_pix1,
    output logic [LUMA_BITS-1:0]                       out_pix2,
    output logic signed [MOMENT_BITS-1:0]              out_xmoment,
    output logic signed [MOMENT_BITS-1:0]              out_ymoment
);

    localparam int C_HALF_X   = (WINDOW_SIZE_X - 1) / 2;
    localparam int C_HALF_Y   = (WINDOW_SIZE_Y - 1) / 2;
    localparam int C_CNT_BITS = $clog2(WINDOW_SIZE_X + 1);
    localparam int C_XI_BITS  = (WINDOW_SIZE_X > 1) ? $clog2(WINDOW_SIZE_X) : 1;
    localparam int C_YI_BITS  = (WINDOW_SIZE_Y > 1) ? $clog2(WINDOW_SIZE_Y) : 1;
    localparam logic [C_CNT_BITS-1:0] C_FULL = C_CNT_BITS'(WINDOW_SIZE_X);

    typedef logic [WINDOW_SIZE_X-1:0][WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0] win_t;

    // Column index 0 is the oldest slot, WINDOW_SIZE_X-1 the newest.
    win_t                    r_win;
    logic [C_CNT_BITS-1:0]   r_cnt;
    logic                    r_patch_valid;
    logic                    r_prev_mode;
    logic [MOMENT_BITS-1:0]  r_xmom;
    logic [MOMENT_BITS-1:0]  r_ymom;

    win_t                    w_win_base;
    win_t                    w_win_next;
    logic [C_CNT_BITS-1:0]   w_cnt_base;
    logic [C_CNT_BITS-1:0]   w_cnt_next;
    logic                    w_restart;
    logic                    w_write;
    logic signed [MOMENT_BITS-1:0] w_xmom_next;
    logic signed [MOMENT_BITS-1:0] w_ymom_next;
    logic [LUMA_BITS-1:0]    w_pix1;
    logic [LUMA_BITS-1:0]    w_pix2;

    // Pixel at a packed {x,y} centre-relative coordinate; zero when outside.
    function automatic logic [LUMA_BITS-1:0] lookup_pix(input win_t win,
                                                        input logic [2*COORD_BITS-1:0] coord);
        int x;
        int y;
        x = int'($signed(coord[2*COORD_BITS-1:COORD_BITS]));
        y = int'($signed(coord[COORD_BITS-1:0]));
        lookup_pix = '0;
        if (coord_in_range(x, C_HALF_X) && coord_in_range(y, C_HALF_Y)) begin
            lookup_pix = win[C_XI_BITS'(coord_to_idx(x, C_HALF_X))]
                            [C_YI_BITS'(coord_to_idx(y, C_HALF_Y))];
        end
    endfunction

    // A restart clears the window first so a same-cycle write becomes column 1.
    always_comb begin
        w_restart  = in_flush | (in_mode & ~r_prev_mode);
        w_write    = in_mode & in_valid;
        w_win_base = w_restart ? '0 : r_win;
        w_cnt_base = w_restart ? '0 : r_cnt;
        w_win_next = w_win_base;
        w_cnt_next = w_cnt_base;
        if (w_write) begin
            w_win_next = {in_col, w_win_base[WINDOW_SIZE_X-1:1]};
            if (w_cnt_base != C_FULL) begin
                w_cnt_next = w_cnt_base + C_CNT_BITS'(1);
            end
        end
    end

    // Moments are computed on the next window so the registered values
    // always match the window contents they are stored alongside.
    orb_moment_calc #(
        .LUMA_BITS     (LUMA_BITS),
        .WINDOW_SIZE_X (WINDOW_SIZE_X),
        .WINDOW_SIZE_Y (WINDOW_SIZE_Y),
        .MOMENT_BITS   (MOMENT_BITS)
    ) u_moment (
        .win     (w_win_next),
        .xmoment (w_xmom_next),
        .ymoment (w_ymom_next)
    );

    // Window, fill count, patch flag, moments and mode history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win         <= '0;
            r_cnt         <= '0;
            r_patch_valid <= 1'b0;
            r_prev_mode   <= 1'b0;
            r_xmom        <= '0;
            r_ymom        <= '0;
        end else begin
            r_win         <= w_win_next;
            r_cnt         <= w_cnt_next;
            r_patch_valid <= (w_cnt_next == C_FULL);
            r_prev_mode   <= in_mode;
            r_xmom        <= w_xmom_next;
            r_ymom        <= w_ymom_next;
        end
    end

    assign w_pix1 = lookup_pix(r_win, in_coord1);
    assign w_pix2 = lookup_pix(r_win, in_coord2);

`ifdef ORB_WINDOW_PIX_REG_EN
    logic [LUMA_BITS-1:0] r_pix1;
    logic [LUMA_BITS-1:0] r_pix2;

    // Registered lookup results to shorten the coordinate mux path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix1 <= '0;
            r_pix2 <= '0;
        end else begin
            r_pix1 <= w_pix1;
            r_pix2 <= w_pix2;
        end
    end

    assign out_pix1 = r_pix1;
    assign out_pix2 = r_pix2;
`else
    assign out_pix1 = w_pix1;
    assign out_pix2 = w_pix2;
`endif

    assign out_patch_valid = r_patch_valid;
    assign out_xmoment     = r_xmom;
    assign out_ymoment     = r_ymom;

endmodule
`default_nettype wire

// File: tb/tb_orb_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_orb_window
// Description : Self-checking bench for orb_window against a queue-based
//               reference model of the sliding patch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_orb_window;
    import orb_window_pkg::*;

    localparam int L  = C_LUMA_BITS;
    localparam int W  = C_WINDOW_SIZE_X;
    localparam int H  = C_WINDOW_SIZE_Y;
    localparam int C  = C_COORD_BITS;
    localparam int M  = C_MOMENT_BITS;
    localparam int HX = (W - 1) / 2;
    localparam int HY = (H - 1) / 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    column_t           in_col;
    logic [2*C-1:0]    in_coord1;
    logic [2*C-1:0]    in_coord2;
    logic              in_flush;
    logic              in_mode;
    logic              out_patch_valid;
    logic [L-1:0]      out_pix1;
    logic [L-1:0]      out_pix2;
    logic [M-1:0]      out_xmoment;
    logic [M-1:0]      out_ymoment;

    int checks = 0;
    int errors = 0;

    // Reference model: valid columns since last restart, newest at the back.
    column_t q[$];
    bit      m_prev = 1'b0;

    orb_window u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_col          (in_col),
        .in_coord1       (in_coord1),
        .in_coord2       (in_coord2),
        .in_flush        (in_flush),
        .in_mode         (in_mode),
        .out_patch_valid (out_patch_valid),
        .out_pix1        (out_pix1),
        .out_pix2        (out_pix2),
        .out_xmoment     (out_xmoment),
        .out_ymoment     (out_ymoment)
    );

    always #5 clk = ~clk;

    function automatic logic [2*C-1:0] enc(input int x, input int y);
        return {C'(x), C'(y)};
    endfunction

    function automatic int pix_xy(input int x, input int y);
        int back;
        if (x < -HX || x > HX || y < -HY || y > HY) return 0;
        back = HX - x;
        if (back >= q.size()) return 0;
        return int'(q[q.size()-1-back][y+HY]);
    endfunction

    function automatic int mpix(input logic [2*C-1:0] coord);
        logic [C-1:0] cx;
        logic [C-1:0] cy;
        cx = coord[2*C-1:C];
        cy = coord[C-1:0];
        return pix_xy(int'($signed(cx)), int'($signed(cy)));
    endfunction

    function automatic int mom_x();
        int s = 0;
        for (int x = -HX; x <= HX; x++)
            for (int y = -HY; y <= HY; y++) s += x * pix_xy(x, y);
        return s;
    endfunction

    function automatic int mom_y();
        int s = 0;
        for (int x = -HX; x <= HX; x++)
            for (int y = -HY; y <= HY; y++) s += y * pix_xy(x, y);
        return s;
    endfunction

    function automatic bit m_full();
        return q.size() == W;
    endfunction

    function automatic void model_apply(input bit mode, input bit valid, input bit flush,
                                        input column_t col);
        if (flush || (mode && !m_prev)) q.delete();
        if (mode && valid) begin
            q.push_back(col);
            if (q.size() > W) void'(q.pop_front());
        end
        m_prev = mode;
    endfunction

    function automatic column_t rand_col();
        return column_t'({$urandom(), $urandom()});
    endfunction

    function automatic column_t pattern_col(input int k);
        column_t c;
        for (int r = 0; r < H; r++) c[r] = L'(16 * r + k);
        return c;
    endfunction

    // One clock with the given controls; outputs sampled 1 time unit after the edge.
    task automatic step(input bit mode, input bit valid, input bit flush, input column_t col);
        in_mode  = mode;
        in_valid = valid;
        in_flush = flush;
        in_col   = col;
        model_apply(mode, valid, flush, col);
        @(posedge clk);
        #1;
    endtask

    // Apply coordinates in read mode and wait until the lookup is visible.
    task automatic look(input logic [2*C-1:0] c1, input logic [2*C-1:0] c2);
        in_coord1 = c1;
        in_coord2 = c2;
`ifdef ORB_WINDOW_PIX_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset_por();
        #2;
        checks++; if (out_patch_valid !== 1'b0) begin errors++; $display("FAIL por_valid got %0b want 0", out_patch_valid); end
        checks++; if (out_xmoment !== '0) begin errors++; $display("FAIL por_xmom got %0d want 0", out_xmoment); end
        checks++; if (out_ymoment !== '0) begin errors++; $display("FAIL por_ymom got %0d want 0", out_ymoment); end
        checks++; if (out_pix1 !== '0) begin errors++; $display("FAIL por_pix1 got %0h want 0", out_pix1); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_fill();
        column_t c;
        step(1'b1, 1'b0, 1'b1, '0);
        for (int i = 1; i <= W; i++) begin
            c = '0;
            c[0] = L'(i);
            step(1'b1, 1'b1, 1'b0, c);
            checks++;
            if (out_patch_valid !== (i == W)) begin
                errors++; $display("FAIL fill_valid write %0d got %0b want %0b", i, out_patch_valid, (i == W));
            end
        end
        checks++; if (out_xmoment !== M'(28)) begin errors++; $display("FAIL fill_xmom got %0d want 28", $signed(out_xmoment)); end
        checks++; if (out_ymoment !== M'(-56)) begin errors++; $display("FAIL fill_ymom got %0d want -56", $signed(out_ymoment)); end
        checks++; if (out_xmoment !== M'(mom_x())) begin errors++; $display("FAIL fill_xmom_model got %0d want %0d", $signed(out_xmoment), mom_x()); end
    endtask

    task automatic test_skip();
        int vals [9] = '{1, 2, 3, 255, 5, 6, 7, 255, 8};
        bit vld  [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 1};
        int nvalid = 0;
        column_t c;
        step(1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 9; i++) begin
            c = '0;
            if (vld[i]) c[0] = L'(vals[i]);
            else        c = {H{8'hFF}};
            step(1'b1, vld[i], 1'b0, c);
            if (vld[i]) nvalid++;
            checks++;
            if (out_patch_valid !== (nvalid == W)) begin
                errors++; $display("FAIL skip_valid step %0d got %0b want %0b", i, out_patch_valid, (nvalid == W));
            end
        end
        checks++; if (out_xmoment !== M'(34)) begin errors++; $display("FAIL skip_xmom got %0d want 34", $signed(out_xmoment)); end
        checks++; if (out_ymoment !== M'(-64)) begin errors++; $display("FAIL skip_ymom got %0d want -64", $signed(out_ymoment)); end
        step(1'b0, 1'b0, 1'b0, '0);
        for (int x = -4; x <= 3; x++) begin
            for (int y = -4; y <= 3; y++) begin
                look(enc(x, y), enc(-x - 1, y));
                checks++;
                if (out_pix1 === 8'hFF || out_pix1 !== L'(mpix(enc(x, y)))) begin
                    errors++; $display("FAIL skip_pix1 (%0d,%0d) got %0h want %0h", x, y, out_pix1, mpix(enc(x, y)));
                end
                checks++;
                if (out_pix2 !== L'(mpix(enc(-x - 1, y)))) begin
                    errors++; $display("FAIL skip_pix2 (%0d,%0d) got %0h want %0h", -x - 1, y, out_pix2, mpix(enc(-x - 1, y)));
                end
            end
        end
    endtask

    task automatic test_lookup();
        step(1'b1, 1'b1, 1'b1, pattern_col(0));
        for (int k = 1; k < W; k++) step(1'b1, 1'b1, 1'b0, pattern_col(k));
        step(1'b0, 1'b0, 1'b0, '0);
        look(enc(0, 0), enc(3, -1));
        checks++; if (out_pix1 !== 8'h23) begin errors++; $display("FAIL look_centre got %0h want 23", out_pix1); end
        checks++; if (out_pix2 !== 8'h16) begin errors++; $display("FAIL look_3m1 got %0h want 16", out_pix2); end
        look(enc(-3, -2), enc(-4, 0));
        checks++; if (out_pix1 !== 8'h00) begin errors++; $display("FAIL look_m3m2 got %0h want 00", out_pix1); end
        checks++; if (out_pix2 !== 8'h00) begin errors++; $display("FAIL look_outside got %0h want 00", out_pix2); end
        look(enc(1, 3), enc(-1, 2));
        checks++; if (out_pix1 !== 8'h00) begin errors++; $display("FAIL look_y3 got %0h want 00", out_pix1); end
        checks++; if (out_pix2 !== 8'h42) begin errors++; $display("FAIL look_m1p2 got %0h want 42", out_pix2); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, rand_col());
            checks++; if (out_xmoment !== M'(140)) begin errors++; $display("FAIL frozen_xmom cyc %0d got %0d want 140", i, $signed(out_xmoment)); end
            checks++; if (out_ymoment !== M'(1120)) begin errors++; $display("FAIL frozen_ymom cyc %0d got %0d want 1120", i, $signed(out_ymoment)); end
            checks++; if (out_patch_valid !== 1'b1) begin errors++; $display("FAIL frozen_valid cyc %0d got %0b want 1", i, out_patch_valid); end
        end
    endtask

    task automatic test_reload();
        for (int k = 0; k < W; k++) begin
            step(1'b1, 1'b1, 1'b0, pattern_col(k));
            checks++;
            if (out_patch_valid !== (k == W - 1)) begin
                errors++; $display("FAIL reload_valid write %0d got %0b want %0b", k + 1, out_patch_valid, (k == W - 1));
            end
        end
        checks++; if (out_xmoment !== M'(140)) begin errors++; $display("FAIL reload_xmom got %0d want 140", $signed(out_xmoment)); end
        checks++; if (out_ymoment !== M'(1120)) begin errors++; $display("FAIL reload_ymom got %0d want 1120", $signed(out_ymoment)); end
    endtask

    task automatic test_flush_mid();
        step(1'b1, 1'b1, 1'b1, rand_col());
        checks++; if (out_patch_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_patch_valid); end
        for (int i = 1; i <= W - 1; i++) begin
            step(1'b1, 1'b1, 1'b0, rand_col());
            checks++;
            if (out_patch_valid !== (i == W - 1)) begin
                errors++; $display("FAIL flush_refill write %0d got %0b want %0b", i, out_patch_valid, (i == W - 1));
            end
            checks++;
            if (out_ymoment !== M'(mom_y())) begin
                errors++; $display("FAIL flush_ymom write %0d got %0d want %0d", i, $signed(out_ymoment), mom_y());
            end
        end
    endtask

    task automatic test_random();
        int e1;
        int e2;
        bit mode;
        bit valid;
        bit flush;
        for (int i = 0; i < 400; i++) begin
            mode  = ($urandom_range(0, 3) != 0);
            valid = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            in_coord1 = (2*C)'($urandom());
            in_coord2 = (2*C)'($urandom());
`ifdef ORB_WINDOW_PIX_REG_EN
            e1 = mpix(in_coord1);
            e2 = mpix(in_coord2);
            step(mode, valid, flush, rand_col());
`else
            step(mode, valid, flush, rand_col());
            e1 = mpix(in_coord1);
            e2 = mpix(in_coord2);
`endif
            checks++; if (out_patch_valid !== m_full()) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", i, out_patch_valid, m_full()); end
            checks++; if (out_xmoment !== M'(mom_x())) begin errors++; $display("FAIL rnd_xmom cyc %0d got %0d want %0d", i, $signed(out_xmoment), mom_x()); end
            checks++; if (out_ymoment !== M'(mom_y())) begin errors++; $display("FAIL rnd_ymom cyc %0d got %0d want %0d", i, $signed(out_ymoment), mom_y()); end
            checks++; if (out_pix1 !== L'(e1)) begin errors++; $display("FAIL rnd_pix1 cyc %0d got %0h want %0h", i, out_pix1, e1); end
            checks++; if (out_pix2 !== L'(e2)) begin errors++; $display("FAIL rnd_pix2 cyc %0d got %0h want %0h", i, out_pix2, e2); end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b1, rand_col());
        for (int i = 0; i < W + 1; i++) step(1'b1, 1'b1, 1'b0, rand_col() | {H{8'h01}});
        in_coord1 = enc(0, 0);
        in_coord2 = enc(3, 2);
        step(1'b0, 1'b0, 1'b0, '0);
        checks++; if (out_patch_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %0b want 1", out_patch_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_patch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_patch_valid); end
        checks++; if (out_xmoment !== '0) begin errors++; $display("FAIL rst_xmom got %0d want 0", $signed(out_xmoment)); end
        checks++; if (out_ymoment !== '0) begin errors++; $display("FAIL rst_ymom got %0d want 0", $signed(out_ymoment)); end
        checks++; if (out_pix1 !== '0) begin errors++; $display("FAIL rst_pix1 got %0h want 0", out_pix1); end
        checks++; if (out_pix2 !== '0) begin errors++; $display("FAIL rst_pix2 got %0h want 0", out_pix2); end
        q.delete();
        m_prev = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_col    = '0;
        in_coord1 = '0;
        in_coord2 = '0;
        in_flush  = 1'b0;
        in_mode   = 1'b0;
        test_reset_por();
        test_fill();
        test_skip();
        test_lookup();
        test_reload();
        test_flush_mid();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/orb_window.md
Name: orb_window

Overview:
- Sliding luma patch buffer for the ORB feature pipeline: WINDOW_SIZE_X columns × WINDOW_SIZE_Y rows.
- Write mode: shifts in one pixel column per valid clock and produces the patch intensity moments (x and y centroid sums) used for ORB orientation.
- Read mode: column input is frozen; two signed (x,y) coordinates are looked up and their pixel values returned for BRIEF sample-pair comparison.

Parameters:
- LUMA_BITS, 8, bits per pixel.
- WINDOW_SIZE_X, 7, window width in columns (odd).
- WINDOW_SIZE_Y, 5, window height in rows (odd).
- COORD_BITS, 3, width of each signed sample coordinate.
- MOMENT_BITS, 16, width of each signed two's-complement moment output.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  current column is valid; invalid columns are skipped.
- in_col  in  WINDOW_SIZE_Y×LUMA_BITS  incoming column; index 0 is the top row.
- in_coord1  in  2×COORD_BITS signed  sample 1 as {x,y}.
- in_coord2  in  2×COORD_BITS signed  sample 2 as {x,y}.
- in_flush  in  1  restart the window.
- in_mode  in  1  1 = write, 0 = read.
- out_patch_valid  out  1  window holds WINDOW_SIZE_X valid columns since the last restart.
- out_pix1  out  LUMA_BITS  pixel at in_coord1.
- out_pix2  out  LUMA_BITS  pixel at in_coord2.
- out_xmoment  out  MOMENT_BITS  Σ x·I over the window.
- out_ymoment  out  MOMENT_BITS  Σ y·I over the window.

Behaviour:
- Reset (async, rst_n=0):
  - window pixels = 0, valid count = 0, out_patch_valid = 0, moments = 0, prev_mode = 0.
  - out_pix = 0 while the window is all zero.
- Coordinate frame:
  - x ∈ [-(W-1)/2, +(W-1)/2] with newest column at x = +(W-1)/2 and oldest at −(W-1)/2.
  - y ∈ [-(H-1)/2, +(H-1)/2] with row 0 at y = −(H-1)/2. Centre pixel is (0,0).
- Restart condition: in_flush=1, or in_mode=1 while prev_mode=0 (read→write transition). prev_mode is registered from in_mode every cycle.
- On restart:
  - valid count → 0 and window pixels → 0 before any same-cycle write is applied.
  - A same-cycle write (in_mode=1, in_valid=1) is accepted as column 1 of the new window.
- Write (in_mode=1 and in_valid=1), on the edge:
  - all columns shift one place toward the oldest slot; the oldest is discarded; in_col enters the newest slot.
  - valid count increments, saturating at WINDOW_SIZE_X.
- in_mode=1 with in_valid=0: window and count unchanged; in_col is ignored.
- Read mode (in_mode=0): window, count, moments and out_patch_valid hold; in_col is ignored.
- out_patch_valid is registered: 1 in the cycle after the edge that makes count == WINDOW_SIZE_X; 0 after any restart edge that leaves the count below WINDOW_SIZE_X.
- Moments:
  - exact sums over all W×H pixels; pixels are unsigned and weights signed.
  - registered, updated on the same edge as the window: outputs always describe the current window contents.
  - Values are only meaningful when out_patch_valid=1 (zero-filled slots contribute 0).
  - The MOMENT_BITS default is sufficient for 7×5×8-bit (max |x| = 7650); wrap on overflow for other parameter sets.
- Pixel lookup:
  - out_pix1/out_pix2 = window[x][y] combinationally from in_coord and the current window, in either mode.
  - Any coordinate outside the window range (e.g. x = −4 or |y| > 2) returns 0.
- Simultaneous events: flush + read mode clears and the window stays empty; flush has priority over the transition detect (identical effect).

Optional Feature:
- ORB_WINDOW_PIX_REG_EN defined: out_pix1/out_pix2 are registered (one-cycle latency from in_coord, reset 0) to cut the lookup mux path.
- Undefined: the lookup is combinational as specified above.

Decomposition:
- Package orb_window_pkg:
  - default parameter constants;
  - pixel/column typedefs;
  - helper functions converting signed coordinate to array index and checking in-range.
- One sub-module, orb_moment_calc: purely combinational Σx·I / Σy·I over a window array. The top level registers its result.

Test Plan:
- Reset: rst_n low mid-stream → patch_valid 0, moments 0, out_pix 0 immediately, without waiting for a clock.
- Fill: flush + 7 valid writes, row0 = 1..7 oldest→newest, other rows 0 → patch_valid 0 after writes 1–6, 1 after write 7; xmoment = 28, ymoment = −56.
- Skip: write row0 values 1,2,3,[0xFF column in_valid=0],5,6,7,[0xFF in_valid=0],8 → patch_valid after 7th valid; xmoment = 34, ymoment = −64; 0xFF never appears.
- Lookup: window pixel[row r][col k] = 16·r + k, read mode → (0,0) → 0x23; (3,−1) → 0x16; (−3,−2) → 0x00; (−4,0) → 0; moments frozen while in_col toggles.
- Reload: read cycle then write mode without flush → 6 valid writes keep patch_valid 0, 7th sets 1; moments equal to the fresh-window values.
- Flush mid-stream: flush + write on cycle N → patch_valid drops to 0 next cycle; returns 1 after 6 more valid writes.
